memory_responder: RTL
=====================

Name: memory_responder

Overview:
- Byte-addressed RAM that acts as the responder side of the memory handshake driven by the ARM control unit (MOV / R_W / MOC).
- Sits between the MAR/MDR datapath and storage. Accepts a request on MOV, performs a read or write after a programmable number of wait states, and asserts MOC.
- Holds MOC until the control unit drops MOV (4-phase handshake).
- Supports byte, halfword and word transfers in big-endian order.

Parameters:
- DEPTH, 256, number of bytes of storage; must be a power of two, ≥ 4.
- WAIT_CYCLES, 2, extra cycles between accepting a request and asserting MOC; 0 to 15 allowed.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  synchronous active-low reset; clr=0 at a rising edge resets the block
- MOV  input  1  memory operation valid (request), driven by control unit
- R_W  input  1  1 = read, 0 = write
- addr  input  32  byte address, from MAR
- data_size  input  2  00 byte, 01 halfword, 10 word, 11 word
- data_in  input  32  write data, from MDR
- data_out  output  32  read data, to MDR
- MOC  output  1  memory operation complete

Behaviour:
- Reset (clr=0 at a rising edge):
  - state=IDLE, MOC=0, data_out=0, wait counter=0.
  - Storage contents are not cleared.
  - A reset in any state aborts the operation in flight; no write is committed.
- FSM states IDLE, BUSY, ACK. All outputs are registered.
- IDLE:
  - On an edge with MOV=1: latch addr, R_W, data_size, data_in; load counter=WAIT_CYCLES; go to BUSY.
  - MOV=0: stay in IDLE.
- BUSY:
  - If MOV=0 at an edge: abort and go to IDLE. No access, MOC stays 0.
  - Else if counter≠0: decrement.
  - Else (counter=0): perform the access on the latched fields, set MOC=1, go to ACK.
- ACK:
  - MOC held at 1 and data_out held stable while MOV=1.
  - On the first edge with MOV=0: MOC=0, go to IDLE.
  - A new request is accepted no earlier than the edge after returning to IDLE.
- Latency: with MOV rising before edge k, MOC is 1 after edge k+1+WAIT_CYCLES (WAIT_CYCLES=0 gives MOC one cycle after acceptance).
- Alignment: the effective address is addr with bit 0 forced to 0 for halfword, and bits 1:0 forced to 0 for word/11. Misalignment is silently truncated, not flagged.
- Range: only addr[log2(DEPTH)-1:0] is used; higher bits are ignored, so addresses wrap modulo DEPTH.
- Big-endian layout: a word at effective address A is mem[A]=bits 31:24, mem[A+1]=bits 23:16, mem[A+2]=bits 15:8, mem[A+3]=bits 7:0. A halfword at A is mem[A]=bits 15:8, mem[A+1]=bits 7:0.
- Read:
  - data_out updated at the same edge MOC rises.
  - Byte and halfword results are zero-extended into the low bits.
  - data_out keeps its last read value through write operations and IDLE.
- Write:
  - Byte writes data_in[7:0]; halfword writes data_in[15:0]; word writes all 32 bits.
  - Bytes are committed at the edge MOC rises.
  - data_out is unchanged by writes.
- The addr, R_W, data_size and data_in pins are ignored after acceptance; only the latched copies are used.

Test Plan:
- Reset and idle: hold clr=0 for 2 edges with MOV=1 → MOC=0, data_out=0x00000000. Release clr with MOV=0 → stays IDLE, MOC=0.
- Word write then read (WAIT_CYCLES=2):
  - Write 0xDEADBEEF to addr 0x10, size 10 → MOC rises 3 edges after acceptance; MOC falls one edge after MOV drops.
  - Read addr 0x10 → data_out=0xDEADBEEF.
  - Byte reads at 0x10..0x13 → 0xDE, 0xAD, 0xBE, 0xEF (zero-extended).
- Byte/halfword write merge:
  - Word-write 0x11223344 at 0x20, then byte-write data_in=0xFFFFFFAA at 0x22 → word read at 0x20 returns 0x1122AA44.
  - Halfword read at 0x23 (aligned to 0x22) returns 0x0000AA44.
- Abort: assert MOV for a write of 0xCAFEF00D at 0x40, drop MOV during BUSY → MOC never rises; word read at 0x40 returns its prior value.
- Wrap and alignment (DEPTH=256):
  - Word write 0x01020304 to addr 0x00000103 → stored at 0x00..0x03.
  - Word read at 0x00000100 → 0x01020304.
- Reset mid-operation: clr=0 while in ACK with MOC=1 → next edge MOC=0, data_out=0. Contents written before the reset remain readable.

Source files
------------

// File: rtl/memory_responder.sv
// Byte-addressed big-endian RAM answering the MOV/R_W/MOC 4-phase handshake,
// completing each request after a programmable number of wait states.
module memory_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        MOV,
    input  logic        R_W,
    input  logic [31:0] addr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        MOC
);
    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [3:0]    r_count;
    logic [3:0]    w_countNext;
    logic [AW-1:0] r_addr;
    logic          r_rw;
    logic [1:0]    r_size;
    logic [31:0]   r_wdata;
    logic          r_moc;
    logic          w_mocNext;
    logic [31:0]   r_dataOut;
    logic [31:0]   w_dataOutNext;
    logic [7:0]    r_mem [DEPTH];

    logic          w_accept;
    logic          w_access;
    logic [AW-1:0] w_a0;
    logic [AW-1:0] w_a1;
    logic [AW-1:0] w_a2;
    logic [AW-1:0] w_a3;
    logic [31:0]   w_readData;
    logic          w_unusedAddrBits;

    // Upper address bits are deliberately dropped so accesses wrap modulo DEPTH
    assign w_unusedAddrBits = ^addr[31:AW];

    assign w_accept = (r_state == IDLE) && MOV;
    assign w_access = (r_state == BUSY) && MOV && (r_count == 4'd0);

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state   <= IDLE;
            r_count   <= 4'd0;
            r_moc     <= 1'b0;
            r_dataOut <= 32'd0;
        end else begin
            r_state   <= w_nextState;
            r_count   <= w_countNext;
            r_moc     <= w_mocNext;
            r_dataOut <= w_dataOutNext;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= addr[AW-1:0];
            r_rw    <= R_W;
            r_size  <= data_size;
            r_wdata <= data_in;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (MOV) w_nextState = BUSY;
            BUSY: begin
                if (!MOV)                   w_nextState = IDLE;
                else if (r_count == 4'd0)   w_nextState = ACK;
            end
            ACK:     if (!MOV) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_countNext = r_count;
        if (w_accept)
            w_countNext = WAIT_LOAD;
        else if ((r_state == BUSY) && MOV && (r_count != 4'd0))
            w_countNext = r_count - 4'd1;
        w_mocNext     = w_access || ((r_state == ACK) && MOV);
        w_dataOutNext = (w_access && r_rw) ? w_readData : r_dataOut;
    end

    // Misaligned addresses are truncated to the natural alignment of the size
    always_comb begin
        w_a0 = r_addr;
        case (r_size)
            2'b00:   w_a0 = r_addr;
            2'b01:   w_a0[0] = 1'b0;
            default: w_a0[1:0] = 2'b00;
        endcase
        w_a1 = w_a0 + AW'(1);
        w_a2 = w_a0 + AW'(2);
        w_a3 = w_a0 + AW'(3);
    end

    always_comb begin
        case (r_size)
            2'b00:   w_readData = {24'd0, r_mem[w_a0]};
            2'b01:   w_readData = {16'd0, r_mem[w_a0], r_mem[w_a1]};
            default: w_readData = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
        endcase
    end

    // Storage is never cleared; a reset coinciding with the access cancels the write
    always_ff @(posedge clk) begin
        if (clr && w_access && !r_rw) begin
            case (r_size)
                2'b00: r_mem[w_a0] <= r_wdata[7:0];
                2'b01: begin
                    r_mem[w_a0] <= r_wdata[15:8];
                    r_mem[w_a1] <= r_wdata[7:0];
                end
                default: begin
                    r_mem[w_a0] <= r_wdata[31:24];
                    r_mem[w_a1] <= r_wdata[23:16];
                    r_mem[w_a2] <= r_wdata[15:8];
                    r_mem[w_a3] <= r_wdata[7:0];
                end
            endcase
        end
    end

    assign MOC      = r_moc;
    assign data_out = r_dataOut;

endmodule
